// File: rtl/gpio_io_arbiter_if.sv
// gpio_io_arbiter_if
// Bundles every requester-side, response-side and device-side signal of the
// GPIO IO arbiter. The signal names match the arbiter's documented port names.
//   slave  : the arbiter's own view. It takes requests and drives the device.
//   master : the environment's view (requesters plus the GPIO controller).
// Handshakes:
//   command  : a command moves when Dev_REQ && Dev_ACK. In that cycle the
//              arbiter raises Req_ACK[g] for the granted requester g.
//   response : slot i moves when Resp_Valid[i] && Resp_Ready[i]. Resp_Ready
//              on an empty slot has no effect.
// REQUESTERS must match the parameter of the arbiter that uses the interface.
interface gpio_io_arbiter_if #(
  parameter int REQUESTERS = 4
);
  logic [REQUESTERS-1:0]    Req_REQ;
  logic [REQUESTERS-1:0]    Req_ACK;
  logic [REQUESTERS-1:0]    Req_CommandEn;
  logic [REQUESTERS-1:0]    Req_ResponseRequested;
  logic [REQUESTERS-1:0]    Req_Lock;
  logic [4*REQUESTERS-1:0]  Req_DestReg;
  logic [16*REQUESTERS-1:0] Req_Data;

  logic [REQUESTERS-1:0]    Resp_Valid;
  logic [REQUESTERS-1:0]    Resp_Ready;
  logic [4*REQUESTERS-1:0]  Resp_DestReg;
  logic [16*REQUESTERS-1:0] Resp_Data;

  logic                     Dev_REQ;
  logic                     Dev_ACK;
  logic                     Dev_CommandEn;
  logic                     Dev_ResponseRequested;
  logic [3:0]               Dev_DestRegIn;
  logic [15:0]              Dev_DataIn;
  logic                     Dev_RegResponseFlag;
  logic [3:0]               Dev_DestRegOut;
  logic [15:0]              Dev_DataOut;

  modport slave (
    input  Req_REQ, Req_CommandEn, Req_ResponseRequested, Req_Lock,
           Req_DestReg, Req_Data, Resp_Ready,
           Dev_ACK, Dev_RegResponseFlag, Dev_DestRegOut, Dev_DataOut,
    output Req_ACK, Resp_Valid, Resp_DestReg, Resp_Data,
           Dev_REQ, Dev_CommandEn, Dev_ResponseRequested, Dev_DestRegIn, Dev_DataIn
  );

  modport master (
    output Req_REQ, Req_CommandEn, Req_ResponseRequested, Req_Lock,
           Req_DestReg, Req_Data, Resp_Ready,
           Dev_ACK, Dev_RegResponseFlag, Dev_DestRegOut, Dev_DataOut,
    input  Req_ACK, Resp_Valid, Resp_DestReg, Resp_Data,
           Dev_REQ, Dev_CommandEn, Dev_ResponseRequested, Dev_DestRegIn, Dev_DataIn
  );
endinterface

// File: rtl/gpio_io_arbiter.sv
// gpio_io_arbiter
// Round-robin arbiter that lets REQUESTERS command sources share one GPIO
// controller IO port. The granted command passes through to the device
// unchanged. Register responses land in per-requester slots, so a slow
// consumer never stalls the device port.
// Ports:
//   clk      : single clock
//   clk_en   : global enable; all state holds and no transfer happens while low
//   sync_rst : synchronous, active-high reset; has priority over clk_en
//   io       : gpio_io_arbiter_if.slave (requesters, response slots, device)
// Parameters:
//   REQUESTERS : 2..8
//   LOCK_MAX   : 1..15; most back-to-back grants one locked requester can get
module gpio_io_arbiter #(
  parameter int REQUESTERS = 4,
  parameter int LOCK_MAX   = 4
) (
  input  logic                clk,
  input  logic                clk_en,
  input  logic                sync_rst,
  gpio_io_arbiter_if.slave    io
);
  localparam int RR_W = $clog2(REQUESTERS);
  localparam logic [3:0]      LOCK_LIM = 4'(LOCK_MAX - 1);
  localparam logic [RR_W-1:0] LAST_IDX = RR_W'(REQUESTERS - 1);

  logic [RR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [3:0]      lock_cnt_q, lock_cnt_d;
  logic [REQUESTERS-1:0] slot_valid_q, slot_valid_d;
  logic [3:0]      slot_dest_q [REQUESTERS];
  logic [3:0]      slot_dest_d [REQUESTERS];
  logic [15:0]     slot_data_q [REQUESTERS];
  logic [15:0]     slot_data_d [REQUESTERS];

  // Unpacked views of the packed requester buses, indexed by grant.
  logic [3:0]      req_dest [REQUESTERS];
  logic [15:0]     req_data [REQUESTERS];

  logic [REQUESTERS-1:0] eligible;
  logic [RR_W-1:0] scan_idx [REQUESTERS];
  logic [RR_W-1:0] grant;
  logic [RR_W-1:0] next_ptr;
  logic            found;
  logic            transfer;

  for (genvar gi = 0; gi < REQUESTERS; gi++) begin : g_lanes
    assign req_dest[gi] = io.Req_DestReg[4*gi +: 4];
    assign req_data[gi] = io.Req_Data[16*gi +: 16];
    assign io.Resp_DestReg[4*gi +: 4] = slot_dest_q[gi];
    assign io.Resp_Data[16*gi +: 16]  = slot_data_q[gi];
  end

  assign io.Resp_Valid = slot_valid_q;

  // A requester that wants a response cannot be granted while its slot is
  // still full. This also rules out a capture and a pop on one slot in the
  // same cycle.
  assign eligible = io.Req_REQ & ~(io.Req_ResponseRequested & slot_valid_q);

  // Scan from the registered pointer and take the first eligible index.
  always_comb begin
    grant = rr_ptr_q;
    found = 1'b0;
    for (int k = 0; k < REQUESTERS; k++) begin
      scan_idx[k] = RR_W'((int'(rr_ptr_q) + k) % REQUESTERS);
    end
    for (int k = 0; k < REQUESTERS; k++) begin
      if (!found && eligible[scan_idx[k]]) begin
        found = 1'b1;
        grant = scan_idx[k];
      end
    end
  end

  assign next_ptr    = (grant == LAST_IDX) ? '0 : grant + RR_W'(1);
  assign io.Dev_REQ  = found & clk_en & ~sync_rst;
  assign transfer    = io.Dev_REQ & io.Dev_ACK;

  always_comb begin
    io.Dev_CommandEn         = 1'b0;
    io.Dev_ResponseRequested = 1'b0;
    io.Dev_DestRegIn         = '0;
    io.Dev_DataIn            = '0;
    io.Req_ACK               = '0;
    if (io.Dev_REQ) begin
      io.Dev_CommandEn         = io.Req_CommandEn[grant];
      io.Dev_ResponseRequested = io.Req_ResponseRequested[grant];
      io.Dev_DestRegIn         = req_dest[grant];
      io.Dev_DataIn            = req_data[grant];
    end
    if (transfer) begin
      io.Req_ACK[grant] = 1'b1;
    end
  end

  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    lock_cnt_d   = lock_cnt_q;
    slot_valid_d = slot_valid_q;
    slot_dest_d  = slot_dest_q;
    slot_data_d  = slot_data_q;
    if (clk_en) begin
      slot_valid_d = slot_valid_q & ~io.Resp_Ready;
      if (transfer) begin
        if (io.Dev_RegResponseFlag) begin
          slot_valid_d[grant] = 1'b1;
          slot_dest_d[grant]  = io.Dev_DestRegOut;
          slot_data_d[grant]  = io.Dev_DataOut;
        end
        // A lock keeps the pointer on the granted requester for at most
        // LOCK_MAX grants in a row. If that requester drops its request,
        // the scan simply moves past it.
        if (io.Req_Lock[grant] && (lock_cnt_q < LOCK_LIM)) begin
          rr_ptr_d   = grant;
          lock_cnt_d = lock_cnt_q + 4'd1;
        end else begin
          rr_ptr_d   = next_ptr;
          lock_cnt_d = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      rr_ptr_q     <= '0;
      lock_cnt_q   <= '0;
      slot_valid_q <= '0;
      for (int i = 0; i < REQUESTERS; i++) begin
        slot_dest_q[i] <= '0;
        slot_data_q[i] <= '0;
      end
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      lock_cnt_q   <= lock_cnt_d;
      slot_valid_q <= slot_valid_d;
      slot_dest_q  <= slot_dest_d;
      slot_data_q  <= slot_data_d;
    end
  end
endmodule
